// File: rtl/if_fetch_queue_if.sv
// Fetch stage bus: instruction memory request/ack plus the decode-side valid/ready queue head.
// The master modport is the fetch unit; the slave modport is the memory/decode environment.
interface if_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH + 1);

    logic          flush_i;
    logic [31:0]   flush_pc_i;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_ack_i;
    logic [31:0]   imem_data_i;
    logic          inst_valid_o;
    logic [31:0]   inst_o;
    logic [31:0]   inst_pc_o;
    logic          inst_ready_i;
    logic [OW-1:0] occupancy_o;

    modport master (
        input  flush_i, flush_pc_i, imem_ack_i, imem_data_i, inst_ready_i,
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, occupancy_o
    );

    modport slave (
        output flush_i, flush_pc_i, imem_ack_i, imem_data_i, inst_ready_i,
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, occupancy_o
    );
endinterface

// File: rtl/if_fetch_queue.sv
// MIPS fetch stage: owns the fetch PC, one outstanding imem request, DEPTH-entry {inst, pc} queue.
// Latency 1 cycle (0 with FETCH_QUEUE_BYPASS_EN); requests are only issued while the queue has space.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic              clk_i,
    input logic              rst_i,
    if_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_drop_addr;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic [PW-1:0] w_occ;
    logic [PW-1:0] w_occ_nxt;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_empty;
    logic          w_space;
    logic          w_ack_req;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop_q;

    assign w_occ     = r_wr_ptr - r_rd_ptr;
    assign w_wr_idx  = r_wr_ptr[AW-1:0];
    assign w_rd_idx  = r_rd_ptr[AW-1:0];
    assign w_empty   = (w_occ == '0);
    assign w_ack_req = (r_state == REQ) && bus.imem_ack_i && !bus.flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_ack_req && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign bus.inst_valid_o = (!w_empty || w_bypass) && !bus.flush_i;
    assign bus.inst_o       = w_bypass ? bus.imem_data_i : r_mem_inst[w_rd_idx];
    assign bus.inst_pc_o    = w_bypass ? r_fetch_pc : r_mem_pc[w_rd_idx];
    assign bus.occupancy_o  = OW'(w_occ);

    // A bypassed word consumed by decode never touches the queue.
    assign w_push  = w_ack_req && !(w_bypass && bus.inst_ready_i);
    assign w_pop_q = bus.inst_valid_o && bus.inst_ready_i && !w_bypass;

    always_comb begin
        w_occ_nxt = w_occ;
        if (bus.flush_i) begin
            w_occ_nxt = '0;
        end else begin
            w_occ_nxt = w_occ + PW'(w_push) - PW'(w_pop_q);
        end
    end

    assign w_space = (w_occ_nxt < PW'(DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_space) w_state_nxt = REQ;
            end
            REQ: begin
                if (bus.flush_i) begin
                    w_state_nxt = bus.imem_ack_i ? REQ : DROP;
                end else if (bus.imem_ack_i && !w_space) begin
                    w_state_nxt = IDLE;
                end
            end
            DROP: begin
                if (bus.imem_ack_i) w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // DROP keeps presenting the abandoned address until memory acks it.
    assign bus.imem_req_o  = (r_state != IDLE);
    assign bus.imem_addr_o = (r_state == DROP) ? r_drop_addr : r_fetch_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (bus.flush_i) begin
                r_fetch_pc <= bus.flush_pc_i;
                if ((r_state == REQ) && !bus.imem_ack_i) r_drop_addr <= r_fetch_pc;
            end else if (w_ack_req) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (bus.flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem_inst[w_wr_idx] <= bus.imem_data_i;
                r_mem_pc[w_wr_idx]   <= r_fetch_pc;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop_q) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end
endmodule
